// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FP mult/div request arbiter.
package fpu_ctrl_pkg;

  localparam int unsigned FP_W = 32;

  typedef struct packed {
    logic io;
    logic dz;
    logic of;
    logic uf;
    logic i;
  } fpu_flags_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } fpu_op_e;

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Bundle of requester, FP unit and response signals around the arbiter.
interface fpu_req_arbiter_if;
  import fpu_ctrl_pkg::*;

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0]           req_sel;
  logic [1:0][FP_W-1:0] req_a;
  logic [1:0][FP_W-1:0] req_b;
  logic                 fpu_en;
  fpu_op_e              fpu_sel;
  logic [FP_W-1:0]      fpu_a;
  logic [FP_W-1:0]      fpu_b;
  logic [FP_W-1:0]      fpu_r;
  fpu_flags_t           fpu_flags;
  logic [1:0]           rsp_valid;
  logic [FP_W-1:0]      rsp_r;
  fpu_flags_t           rsp_flags;
  logic                 busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_sel, req_a, req_b, fpu_r, fpu_flags,
    output req_ready, fpu_en, fpu_sel, fpu_a, fpu_b, rsp_valid, rsp_r, rsp_flags, busy
  );

  // Client engines plus FP datapath side.
  modport master (
    output req_valid, req_sel, req_a, req_b, fpu_r, fpu_flags,
    input  req_ready, fpu_en, fpu_sel, fpu_a, fpu_b, rsp_valid, rsp_r, rsp_flags, busy
  );

endinterface

// File: rtl/fpu_req_arbiter_tag_pipe.sv
// Reset-clearable shift register carrying {vld, id} alongside the FP unit latency.
module fpu_tag_pipe #(
  parameter int unsigned DEPTH = 23,
  parameter int unsigned W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         vld_i,
  input  logic [W-1:0] id_i,
  output logic         vld_o,
  output logic [W-1:0] id_o
);

  logic [DEPTH-1:0]        vld_q;
  logic [DEPTH-1:0][W-1:0] id_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= vld_i;
      id_q[0]  <= id_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign id_o  = id_q[DEPTH-1];

endmodule

// File: rtl/fpu_req_arbiter.sv
// Round-robin sharing of one pipelined FP mult/div unit between two requesters,
// with per-requester credit counters and result routing by issue tag.
module fpu_req_arbiter
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned LAT     = 23,
  parameter int unsigned MAX_OUT = 8
) (
  input logic              clk,
  input logic              arst,
  fpu_req_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_OUT + 1);

  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic                 rr_q, rr_d;
  logic [1:0]           free, elig, ready, acc;
  logic                 any_acc;

  logic                 fpu_en_q;
  fpu_op_e              fpu_sel_q;
  logic [FP_W-1:0]      fpu_a_q, fpu_b_q;
  logic                 id_q;

  logic                 tag_vld;
  logic [0:0]           tag_id;
  logic [1:0]           rsp_valid_q;
  logic [FP_W-1:0]      rsp_r_q;
  fpu_flags_t           rsp_flags_q;

  // A response retiring this cycle frees its credit immediately, so a full
  // requester can be accepted in the same cycle its oldest result returns.
  always_comb begin
    free    = '0;
    elig    = '0;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      free[i] = (cnt_q[i] != CntW'(MAX_OUT)) | rsp_valid_q[i];
      elig[i] = bus.req_valid[i] & free[i];
    end
    // Ready never looks at the requester's own valid; only valid & ready counts.
    ready[0] = free[0] & (~rr_q | ~elig[1]);
    ready[1] = free[1] & (rr_q | ~elig[0]);
    acc      = bus.req_valid & ready;
    any_acc  = |acc;
    rr_d     = any_acc ? acc[0] : rr_q;
    for (int unsigned i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i] + CntW'(acc[i]) - CntW'(rsp_valid_q[i]);
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      fpu_en_q    <= 1'b0;
      fpu_sel_q   <= OP_MUL;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      fpu_en_q <= any_acc;
      if (any_acc) begin
        id_q      <= acc[1];
        fpu_sel_q <= fpu_op_e'(bus.req_sel[acc[1]]);
        fpu_a_q   <= bus.req_a[acc[1]];
        fpu_b_q   <= bus.req_b[acc[1]];
      end
      rsp_valid_q <= {tag_vld & tag_id[0], tag_vld & ~tag_id[0]};
      if (tag_vld) begin
        rsp_r_q     <= bus.fpu_r;
        rsp_flags_q <= bus.fpu_flags;
      end
    end
  end

  fpu_tag_pipe #(
    .DEPTH (LAT),
    .W     (1)
  ) u_tag_pipe (
    .clk_i  (clk),
    .rst_ni (arst),
    .vld_i  (fpu_en_q),
    .id_i   (id_q),
    .vld_o  (tag_vld),
    .id_o   (tag_id)
  );

  assign bus.req_ready = ready;
  assign bus.fpu_en    = fpu_en_q;
  assign bus.fpu_sel   = fpu_sel_q;
  assign bus.fpu_a     = fpu_a_q;
  assign bus.fpu_b     = fpu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_r     = rsp_r_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.busy      = |cnt_q;

endmodule
